// File: rtl/pipe_skid_reg_if.sv
// Handshake and control bundle for one elastic pipeline stage.
// The master drives the upstream entry, downstream ready and the stall/kill
// controls; the slave (the stage itself) returns readiness, the output entry
// and its status counters.
interface pipe_skid_reg_if #(
  parameter int DATA_W = 128,
  parameter int SIDE_W = 32,
  parameter int CNT_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [SIDE_W-1:0] in_side;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [SIDE_W-1:0] out_side;
  logic              flush;
  logic              bubble;
  logic              freeze;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  drop_cnt;

  modport master (
    output in_valid, in_data, in_side, out_ready, flush, bubble, freeze,
    input  in_ready, out_valid, out_data, out_side, occupancy, drop_cnt
  );

  modport slave (
    input  in_valid, in_data, in_side, out_ready, flush, bubble, freeze,
    output in_ready, out_valid, out_data, out_side, occupancy, drop_cnt
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline-stage register with an optional 2-entry skid buffer.
// The main entry drives the output; the skid entry catches one extra input
// so that in_ready never depends combinationally on out_ready (SKID=1).
// The side field (e.g. PC) is refreshed on flush/bubble even though the
// entry itself becomes invalid.
module pipe_skid_reg #(
  parameter int DATA_W      = 128,
  parameter int SIDE_W      = 32,
  parameter int SKID        = 1,
  parameter int CLR_ON_KILL = 1,
  parameter int CNT_W       = 8
) (
  input  logic           clk,
  input  logic           rst,
  pipe_skid_reg_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_main_data, w_main_data_next;
  logic [SIDE_W-1:0] r_main_side, w_main_side_next;
  logic [DATA_W-1:0] r_skid_data, w_skid_data_next;
  logic [SIDE_W-1:0] r_skid_side, w_skid_side_next;
  logic [CNT_W-1:0]  r_drop_cnt, w_drop_cnt_next;

  logic              w_main_valid;
  logic              w_skid_valid;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_in_fire;
  logic              w_out_fire;
  logic [1:0]        w_kill;
  logic [CNT_W:0]    w_drop_sum;

  assign w_main_valid = (r_state != ST_EMPTY);
  assign w_skid_valid = (r_state == ST_FULL);
  assign w_out_valid  = w_main_valid & ~bus.freeze & ~bus.flush;

  // With a skid slot, readiness only looks at our own fill level; without
  // one, the single slot can be refilled only when it drains this cycle.
  if (SKID != 0) begin : g_skid_ready
    assign w_in_ready = (r_state != ST_FULL) & ~bus.freeze & ~bus.flush
                        & ~bus.bubble & ~rst;
  end else begin : g_pass_ready
    assign w_in_ready = ((r_state == ST_EMPTY) | bus.out_ready) & ~bus.freeze
                        & ~bus.flush & ~bus.bubble & ~rst;
  end

  assign w_in_fire  = bus.in_valid & w_in_ready;
  assign w_out_fire = w_out_valid & bus.out_ready;

  // Saturating add of the entries a flush kills; one extra bit detects overflow.
  assign w_kill     = {1'b0, w_main_valid} + {1'b0, w_skid_valid};
  assign w_drop_sum = {1'b0, r_drop_cnt} + (CNT_W+1)'(w_kill);

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_main_data <= '0;
      r_main_side <= '0;
      r_skid_data <= '0;
      r_skid_side <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_main_data <= w_main_data_next;
      r_main_side <= w_main_side_next;
      r_skid_data <= w_skid_data_next;
      r_skid_side <= w_skid_side_next;
      r_drop_cnt  <= w_drop_cnt_next;
    end
  end

  // Next-state: flush empties, freeze holds, otherwise follow the fires.
  always_comb begin
    w_state_next = r_state;
    if (bus.flush) begin
      w_state_next = ST_EMPTY;
    end else if (!bus.freeze) begin
      case (r_state)
        ST_EMPTY: if (w_in_fire) w_state_next = ST_ONE;
        ST_ONE: begin
          if (w_in_fire && !w_out_fire)      w_state_next = ST_FULL;
          else if (!w_in_fire && w_out_fire) w_state_next = ST_EMPTY;
        end
        ST_FULL:  if (w_out_fire) w_state_next = ST_ONE;
        default:  w_state_next = ST_EMPTY;
      endcase
    end
  end

  // Datapath next values: load, shift skid into main, or kill on flush/bubble.
  always_comb begin
    w_main_data_next = r_main_data;
    w_main_side_next = r_main_side;
    w_skid_data_next = r_skid_data;
    w_skid_side_next = r_skid_side;
    w_drop_cnt_next  = r_drop_cnt;
    if (bus.flush) begin
      w_main_side_next = bus.in_side;
      if (CLR_ON_KILL != 0) begin
        w_main_data_next = '0;
        w_skid_data_next = '0;
        w_skid_side_next = '0;
      end
      w_drop_cnt_next = w_drop_sum[CNT_W] ? {CNT_W{1'b1}} : w_drop_sum[CNT_W-1:0];
    end else if (!bus.freeze) begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_main_data_next = bus.in_data;
            w_main_side_next = bus.in_side;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_data_next = bus.in_data;
            w_main_side_next = bus.in_side;
          end else if (w_in_fire) begin
            w_skid_data_next = bus.in_data;
            w_skid_side_next = bus.in_side;
          end else if (w_out_fire && bus.bubble) begin
            // Refill with an invalid entry that still carries the new side.
            w_main_side_next = bus.in_side;
            if (CLR_ON_KILL != 0) w_main_data_next = '0;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            w_main_data_next = r_skid_data;
            w_main_side_next = r_skid_side;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_main_data;
  assign bus.out_side  = r_main_side;
  assign bus.occupancy = {1'b0, w_main_valid} + {1'b0, w_skid_valid};
  assign bus.drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg (SKID=1, CNT_W=2 to reach saturation).
module tb_pipe_skid_reg;
  localparam int DATA_W = 32;
  localparam int SIDE_W = 16;
  localparam int CNT_W  = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SIDE_W-1:0] side;
  } entry_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_bad = 0;
  entry_t q[$];
  int   m_drop = 0;

  pipe_skid_reg_if #(.DATA_W(DATA_W), .SIDE_W(SIDE_W), .CNT_W(CNT_W)) bus ();

  pipe_skid_reg #(
    .DATA_W(DATA_W), .SIDE_W(SIDE_W), .SKID(1), .CLR_ON_KILL(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Model checks and scoreboard update, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    bit exp_ir, exp_ov;
    entry_t e;
    if (!rst) begin
      exp_ir = (q.size() < 2) && !bus.freeze && !bus.flush && !bus.bubble;
      exp_ov = (q.size() > 0) && !bus.freeze && !bus.flush;
      chk("in_ready", bus.in_ready, exp_ir);
      chk("out_valid", bus.out_valid, exp_ov);
      chk("occupancy", bus.occupancy, q.size());
      chk("drop_cnt", bus.drop_cnt, m_drop);
      if (bus.flush) begin
        m_drop = (m_drop + q.size() > CNT_MAX) ? CNT_MAX : m_drop + q.size();
        q.delete();
      end else begin
        if (exp_ov && bus.out_ready) begin
          e = q.pop_front();
          $display("out data=0x%0h side=0x%0h", bus.out_data, bus.out_side);
          chk("out_data", bus.out_data, e.data);
          chk("out_side", bus.out_side, e.side);
        end
        if (exp_ir && bus.in_valid) begin
          q.push_back({bus.in_data, bus.in_side});
          $display("in  data=0x%0h side=0x%0h", bus.in_data, bus.in_side);
        end
      end
    end
  end

  // Cycle budget so a stuck run still terminates.
  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL timeout cycles=5000 limit=5000");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    m_drop = 0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic load(input logic [DATA_W-1:0] d, input logic [SIDE_W-1:0] s);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_side  = s;
    cyc();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid = 0; bus.in_data = '0; bus.in_side = '0;
    bus.out_ready = 0; bus.flush = 0; bus.bubble = 0; bus.freeze = 0;
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    do_reset();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_side", bus.out_side, 0);
    chk("rst_occ", bus.occupancy, 0);
    chk("rst_drop", bus.drop_cnt, 0);

    // 1: streaming
    bus.out_ready = 1;
    for (int i = 1; i <= 3; i++) begin
      bus.in_valid = 1; bus.in_data = i; bus.in_side = 16'h10 + i;
      cyc();
      chk("t1_data", bus.out_data, i);
      chk("t1_occ", bus.occupancy, 1);
      chk("t1_ready", bus.in_ready, 1);
    end
    bus.in_valid = 0;
    cyc();
    chk("t1_drain", bus.occupancy, 0);

    // 2: backpressure into the skid slot
    bus.out_ready = 0;
    load(32'hA, 16'hA0);
    load(32'hB, 16'hB0);
    chk("t2_ready", bus.in_ready, 0);
    chk("t2_occ", bus.occupancy, 2);
    chk("t2_head", bus.out_data, 32'hA);
    bus.out_ready = 1;
    cyc();
    chk("t2_second", bus.out_data, 32'hB);
    chk("t2_occ1", bus.occupancy, 1);
    cyc();
    chk("t2_occ0", bus.occupancy, 0);
    bus.out_ready = 0;

    // 3: flush while FULL, then while EMPTY
    load(32'hC, 16'hC0);
    load(32'hD, 16'hD0);
    bus.flush = 1; bus.in_side = 16'h100;
    #1;
    chk("t3_ov_same", bus.out_valid, 0);
    cyc();
    bus.flush = 0;
    chk("t3_side", bus.out_side, 16'h100);
    chk("t3_data", bus.out_data, 0);
    chk("t3_drop", bus.drop_cnt, 2);
    bus.flush = 1;
    cyc();
    bus.flush = 0;
    chk("t3_drop_empty", bus.drop_cnt, 2);

    // 4: flush overrides freeze; freeze alone holds everything
    load(32'hE, 16'hE0);
    bus.freeze = 1; bus.flush = 1;
    #1;
    chk("t4_ov_same", bus.out_valid, 0);
    cyc();
    bus.freeze = 0; bus.flush = 0;
    chk("t4_drop", bus.drop_cnt, 3);
    chk("t4_occ", bus.occupancy, 0);
    load(32'hF, 16'hF0);
    bus.freeze = 1; bus.in_valid = 1; bus.in_data = 32'h6; bus.in_side = 16'h60;
    bus.out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t4_frz_ready", bus.in_ready, 0);
      chk("t4_frz_data", bus.out_data, 32'hF);
      chk("t4_frz_occ", bus.occupancy, 1);
      chk("t4_frz_drop", bus.drop_cnt, 3);
    end
    bus.freeze = 0; bus.in_valid = 0;
    cyc();
    chk("t4_after", bus.occupancy, 0);
    bus.out_ready = 0;

    // 5: bubble drains ONE and refreshes the side field
    load(32'h55, 16'h5);
    bus.bubble = 1; bus.out_ready = 1; bus.in_valid = 1;
    bus.in_data = 32'h99; bus.in_side = 16'h44;
    #1;
    chk("t5_ready0", bus.in_ready, 0);
    cyc();
    chk("t5_ov", bus.out_valid, 0);
    chk("t5_side", bus.out_side, 16'h44);
    chk("t5_data", bus.out_data, 0);
    chk("t5_ready1", bus.in_ready, 0);
    cyc();
    chk("t5_ready2", bus.in_ready, 0);
    bus.bubble = 0; bus.in_valid = 0; bus.out_ready = 0;
    cyc();

    // 6: drop counter saturation, then asynchronous reset while FULL
    do_reset();
    for (int i = 0; i < 4; i++) begin
      load(32'h60 + i, 16'h600 + i);
      bus.flush = 1;
      cyc();
      bus.flush = 0;
      chk("t6_sat", bus.drop_cnt, (i < 3) ? i + 1 : 3);
    end
    load(32'h70, 16'h700);
    load(32'h71, 16'h701);
    #2;
    rst = 1;
    q.delete();
    m_drop = 0;
    #1;
    chk("t6_rst_ov", bus.out_valid, 0);
    chk("t6_rst_occ", bus.occupancy, 0);
    chk("t6_rst_data", bus.out_data, 0);
    chk("t6_rst_side", bus.out_side, 0);
    chk("t6_rst_drop", bus.drop_cnt, 0);
    chk("t6_rst_ready", bus.in_ready, 0);
    cyc();
    rst = 0;
    cyc();
    chk("t6_post_occ", bus.occupancy, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
